// File: rtl/bin2bcd_seq.sv
// bin2bcd_seq: sequential binary-to-BCD converter for the 7-segment display path.
// A signed (or unsigned) word is captured, reduced to its magnitude, and run
// through a shift-add-3 (double-dabble) engine one bit per clock. When the
// last bit has been shifted in, the BCD digits and a sign digit are
// registered and o_rdy stays high until the next request or reset.
//
// Handshake: o_rdy is a level-valid flag. It is high exactly while o_digits and
// o_sign hold a finished result (state DONE). i_start is a request that is
// accepted on any rising edge where the block is not busy (IDLE or DONE). It is
// ignored while o_busy is high. There is no back-pressure and no queuing.
module bin2bcd_seq #(
  parameter int DW       = 16,
  parameter int NDIG     = 5,
  parameter bit SIGNED   = 1'b1,
  parameter bit BLANK_LZ = 1'b0
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_start,
  input  logic [DW-1:0]     i_data,
  output logic              o_busy,
  output logic              o_rdy,
  output logic [3:0]        o_sign,
  output logic [4*NDIG-1:0] o_digits
);

  localparam int WW = 4 * NDIG;
  localparam int CW = $clog2(DW + 1);

  localparam logic [3:0] SIGN_CODE  = 4'd10;
  localparam logic [3:0] BLANK_CODE = 4'hF;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  // The digit count must hold the largest magnitude, 2^DW - 1 (or 2^(DW-1)).
  function automatic bit digits_fit();
    longint unsigned p;
    longint unsigned lim;
    bit ok;
    p   = 64'd1;
    lim = 64'd1 << DW;
    ok  = 1'b0;
    for (int i = 0; i < NDIG; i++) begin
      if (!ok) begin
        p = p * 64'd10;
        if (p > lim) ok = 1'b1;
      end
    end
    return ok;
  endfunction

  if (!digits_fit()) begin : g_ndig_check
    $error("bin2bcd_seq: NDIG too small, need 10^NDIG > 2^DW");
  end

  // Add 3 to every BCD digit that is 5 or more, all digits in parallel.
  function automatic logic [WW-1:0] add3_all(input logic [WW-1:0] w);
    logic [WW-1:0] r;
    r = w;
    for (int i = 0; i < NDIG; i++) begin
      if (w[4*i +: 4] >= 4'd5) r[4*i +: 4] = w[4*i +: 4] + 4'd3;
    end
    return r;
  endfunction

  // Replace zero digits above the highest nonzero digit with blank codes.
  // Digit 0 is always left numeric so a zero value still shows "0".
  function automatic logic [WW-1:0] blank_lz(input logic [WW-1:0] w);
    logic [WW-1:0] r;
    logic          seen;
    r    = w;
    seen = 1'b0;
    for (int i = NDIG - 1; i >= 1; i--) begin
      if (w[4*i +: 4] != 4'd0) seen = 1'b1;
      if (!seen) r[4*i +: 4] = BLANK_CODE;
    end
    return r;
  endfunction

  state_t          state_q, state_d;
  logic [DW-1:0]   mag_q, mag_d;
  logic [WW-1:0]   work_q, work_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            neg_q, neg_d;
  logic [WW-1:0]   digits_q, digits_d;
  logic [3:0]      sign_q, sign_d;

  logic            accept;
  logic            last_shift;
  logic [WW-1:0]   work_adj;
  logic [WW-1:0]   work_shifted;

  assign accept       = i_start && (state_q != ST_SHIFT);
  assign last_shift   = (state_q == ST_SHIFT) && (cnt_q == CW'(DW - 1));
  assign work_adj     = add3_all(work_q);
  assign work_shifted = {work_adj[WW-2:0], mag_q[DW-1]};

  // State and datapath registers with synchronous reset.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q  <= ST_IDLE;
      mag_q    <= '0;
      work_q   <= '0;
      cnt_q    <= '0;
      neg_q    <= 1'b0;
      digits_q <= '0;
      sign_q   <= BLANK_CODE;
    end else begin
      state_q  <= state_d;
      mag_q    <= mag_d;
      work_q   <= work_d;
      cnt_q    <= cnt_d;
      neg_q    <= neg_d;
      digits_q <= digits_d;
      sign_q   <= sign_d;
    end
  end

  // Next-state logic: IDLE/DONE -> SHIFT on request, SHIFT -> DONE after DW shifts.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (i_start) state_d = ST_SHIFT;
      ST_SHIFT: if (last_shift) state_d = ST_DONE;
      ST_DONE:  if (i_start) state_d = ST_SHIFT;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Datapath next values: capture on accept, one add-3/shift step per SHIFT cycle.
  always_comb begin
    mag_d    = mag_q;
    work_d   = work_q;
    cnt_d    = cnt_q;
    neg_d    = neg_q;
    digits_d = digits_q;
    sign_d   = sign_q;
    if (accept) begin
      // Negating the most negative value wraps back to 2^(DW-1), which is
      // exactly the wanted magnitude when read as unsigned.
      mag_d  = (SIGNED && i_data[DW-1]) ? DW'(-i_data) : i_data;
      neg_d  = SIGNED && i_data[DW-1];
      work_d = '0;
      cnt_d  = '0;
    end else if (state_q == ST_SHIFT) begin
      work_d = work_shifted;
      mag_d  = {mag_q[DW-2:0], 1'b0};
      cnt_d  = cnt_q + CW'(1);
      if (last_shift) begin
        digits_d = BLANK_LZ ? blank_lz(work_shifted) : work_shifted;
        sign_d   = neg_q ? SIGN_CODE : BLANK_CODE;
      end
    end
  end

  // Outputs: status flags decoded from state, result from its registers.
  always_comb begin
    o_busy   = (state_q == ST_SHIFT);
    o_rdy    = (state_q == ST_DONE);
    o_digits = digits_q;
    o_sign   = sign_q;
  end

endmodule

// File: tb/tb_bin2bcd_seq.sv
// tb_bin2bcd_seq: bench for bin2bcd_seq. Two instances share the inputs: one
// with default parameters and one with leading-zero blanking enabled.
// Expected digits come from a decimal model using division and modulo.
module tb_bin2bcd_seq;

  localparam int DW   = 16;
  localparam int NDIG = 5;
  localparam int LAT  = DW;

  // Clock and reset.
  logic clk;
  logic rst;
  logic start;
  logic [DW-1:0] data;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic              busy_a, rdy_a, busy_b, rdy_b;
  logic [3:0]        sign_a, sign_b;
  logic [4*NDIG-1:0] dig_a, dig_b;

  bin2bcd_seq #(.DW(DW), .NDIG(NDIG), .SIGNED(1'b1), .BLANK_LZ(1'b0)) u_dut (
    .i_clk(clk), .i_rst(rst), .i_start(start), .i_data(data),
    .o_busy(busy_a), .o_rdy(rdy_a), .o_sign(sign_a), .o_digits(dig_a)
  );

  bin2bcd_seq #(.DW(DW), .NDIG(NDIG), .SIGNED(1'b1), .BLANK_LZ(1'b1)) u_blank (
    .i_clk(clk), .i_rst(rst), .i_start(start), .i_data(data),
    .o_busy(busy_b), .o_rdy(rdy_b), .o_sign(sign_b), .o_digits(dig_b)
  );

  int errors = 0;
  int checks = 0;

  // Last result each instance should be holding.
  logic [4*NDIG-1:0] last_a, last_b;
  logic [3:0]        last_sa, last_sb;

  // Reference model: decimal digits of |v| via plain arithmetic.
  function automatic logic [4*NDIG-1:0] ref_digits(input logic [DW-1:0] v, input bit blank);
    int sv;
    int mag;
    logic [4*NDIG-1:0] r;
    bit seen;
    sv  = int'($signed(v));
    mag = (sv < 0) ? -sv : sv;
    for (int i = 0; i < NDIG; i++) begin
      r[4*i +: 4] = 4'(mag % 10);
      mag = mag / 10;
    end
    if (blank) begin
      seen = 1'b0;
      for (int i = NDIG - 1; i >= 1; i--) begin
        if (r[4*i +: 4] != 4'd0) seen = 1'b1;
        if (!seen) r[4*i +: 4] = 4'hF;
      end
    end
    return r;
  endfunction

  function automatic logic [3:0] ref_sign(input logic [DW-1:0] v);
    return (int'($signed(v)) < 0) ? 4'd10 : 4'hF;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_idle_reset(input string tag);
    chk({tag, "_busy_a"}, 32'(busy_a), 32'd0);
    chk({tag, "_rdy_a"}, 32'(rdy_a), 32'd0);
    chk({tag, "_dig_a"}, 32'(dig_a), 32'd0);
    chk({tag, "_sign_a"}, 32'(sign_a), 32'hF);
    chk({tag, "_busy_b"}, 32'(busy_b), 32'd0);
    chk({tag, "_rdy_b"}, 32'(rdy_b), 32'd0);
    chk({tag, "_dig_b"}, 32'(dig_b), 32'd0);
    chk({tag, "_sign_b"}, 32'(sign_b), 32'hF);
  endtask

  // Driver: one conversion, entered and left at a falling edge. A stray
  // request with value 99 is injected after shift cycle ign_at (-1 = none).
  task automatic conv(input string tag, input logic [DW-1:0] v, input int ign_at);
    start = 1'b1;
    data  = v;
    @(negedge clk);                     // edge k has accepted the request
    start = 1'b0;
    data  = 16'($urandom);
    for (int j = 0; j < LAT; j++) begin
      chk({tag, "_busy"}, 32'({busy_a, busy_b}), 32'b11);
      chk({tag, "_rdy"}, 32'({rdy_a, rdy_b}), 32'b00);
      if (j == 0 || j == LAT - 1) begin
        chk({tag, "_hold_a"}, 32'(dig_a), 32'(last_a));
        chk({tag, "_hold_b"}, 32'(dig_b), 32'(last_b));
        chk({tag, "_hold_s"}, 32'({sign_a, sign_b}), 32'({last_sa, last_sb}));
      end
      start = (j == ign_at);
      data  = (j == ign_at) ? 16'd99 : 16'($urandom);
      @(negedge clk);
      start = 1'b0;
    end
    // Edge k+LAT has passed: the result must be present.
    last_a  = ref_digits(v, 1'b0);
    last_b  = ref_digits(v, 1'b1);
    last_sa = ref_sign(v);
    last_sb = ref_sign(v);
    chk({tag, "_rdy_done"}, 32'({rdy_a, rdy_b}), 32'b11);
    chk({tag, "_busy_done"}, 32'({busy_a, busy_b}), 32'b00);
    chk({tag, "_dig_a"}, 32'(dig_a), 32'(last_a));
    chk({tag, "_dig_b"}, 32'(dig_b), 32'(last_b));
    chk({tag, "_sign_a"}, 32'(sign_a), 32'(last_sa));
    chk({tag, "_sign_b"}, 32'(sign_b), 32'(last_sb));
  endtask

  task automatic clear_last();
    last_a  = '0;
    last_b  = '0;
    last_sa = 4'hF;
    last_sb = 4'hF;
  endtask

  initial begin
    rst   = 1'b1;
    start = 1'b0;
    data  = '0;
    clear_last();

    // Reset held for two edges, then a request that reset must override.
    repeat (2) @(negedge clk);
    chk_idle_reset("reset");
    start = 1'b1;
    data  = 16'd1234;
    @(negedge clk);
    start = 1'b0;
    chk_idle_reset("reset_start");
    rst = 1'b0;
    @(negedge clk);
    chk_idle_reset("idle");

    // Directed values, including the most negative and largest positive.
    conv("d1234", 16'd1234, -1);
    conv("dm1", 16'hFFFF, -1);
    conv("dmin", 16'h8000, -1);
    conv("dmax", 16'h7FFF, -1);
    conv("dzero", 16'd0, -1);
    conv("dm5", 16'hFFFB, -1);
    conv("d10000", 16'd10000, -1);

    // A request during SHIFT is ignored; a request in DONE restarts.
    conv("d42_ign", 16'd42, 4);
    repeat (3) @(negedge clk);
    chk("done_hold_rdy", 32'({rdy_a, rdy_b}), 32'b11);
    chk("done_hold_dig", 32'(dig_a), 32'h00042);
    conv("d99", 16'd99, -1);

    // Reset in the middle of a conversion (after 8 shifts).
    start = 1'b1;
    data  = 16'd31415;
    @(negedge clk);
    start = 1'b0;
    repeat (8) @(negedge clk);
    chk("mid_busy", 32'(busy_a), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    clear_last();
    chk_idle_reset("mid_rst");
    conv("d7", 16'd7, -1);

    // Random values, some back-to-back from DONE, some after idle gaps.
    for (int n = 0; n < 24; n++) begin
      if ($urandom_range(0, 1) == 1) repeat ($urandom_range(1, 3)) @(negedge clk);
      conv("rnd", 16'($urandom), ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, LAT - 2)) : -1);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/bin2bcd_seq.md
Name: bin2bcd_seq

Overview:
Sequential binary-to-BCD converter that produces the digit stream consumed by the team's BCD-to-7-segment display decoders. It accepts a signed two's-complement result from the MDR datapath and converts its magnitude with an iterative shift-add-3 (double-dabble) engine, one bit per clock. It presents NDIG BCD digits, a sign digit, and a level-valid o_rdy that drives each decoder's i_rdy input directly.

Parameters:
DW, 16, input word width in bits (two's complement when SIGNED=1).
NDIG, 5, number of BCD digits output; must satisfy 10^NDIG > 2^DW (checked by elaboration assertion).
SIGNED, 1, 1 = i_data is two's complement; 0 = i_data is unsigned and o_sign is always 4'hF.
BLANK_LZ, 0, 1 = leading-zero digits are output as 4'hF (blank); the least-significant digit is never blanked.

Ports:
i_clk  input  1  clock; all logic on rising edge.
i_rst  input  1  synchronous reset, active-high.
i_start  input  1  conversion request; sampled only in IDLE or DONE.
i_data  input  DW  value to convert; sampled on the edge that accepts i_start.
o_busy  output  1  high while in SHIFT.
o_rdy  output  1  high while o_digits and o_sign hold a completed result.
o_sign  output  4  4'd10 (SIGN code) if the captured value is negative, else 4'hF (blank).
o_digits  output  4*NDIG  BCD digits; [3:0] = units, [4*NDIG-1:4*NDIG-4] = most significant.

Behaviour:
- Reset: on any edge with i_rst=1, the state goes to IDLE and o_busy=0, o_rdy=0, o_digits=0, o_sign=4'hF, and the internal registers clear. Reset overrides i_start and applies mid-conversion with no partial result exposed.
- States: IDLE, SHIFT, DONE.
- IDLE/DONE with i_start=1 (edge k):
  - Capture mag = |i_data| as a DW-bit unsigned value (SIGNED=1 and i_data[DW-1]=1 -> two's-complement negate; -2^(DW-1) yields 2^(DW-1) with no overflow).
  - Capture neg = SIGNED & i_data[DW-1], clear the BCD work register, set cnt=0.
  - Set o_rdy=0, o_busy=1, go to SHIFT.
  - o_digits and o_sign hold their previous values.
- SHIFT, each edge:
  - For every work digit >= 5, add 3 (all digits in parallel, same cycle).
  - Shift {work, mag} left by 1.
  - cnt++.
- End of SHIFT: on the edge where cnt reaches DW-1 -> DW (the DW-th shift), register the adjusted-and-shifted work value into o_digits (with blanking applied). Also set o_sign = neg ? 10 : 4'hF, o_rdy=1, o_busy=0, and go to DONE.
- Latency: o_rdy rises exactly DW edges after edge k (16 cycles at default). Throughput is one conversion per DW+1 cycles.
- i_start during SHIFT is ignored: no restart and no queuing.
- DONE holds outputs and o_rdy=1 indefinitely until the next i_start or i_rst.
- Blanking (BLANK_LZ=1): scan from the MSD downward. Every digit above the highest nonzero digit becomes 4'hF; digit 0 is always numeric. Blanking is computed combinationally from the final work value and registered with it.
- Zero input: no sign. -0 cannot occur, so value 0 always gives o_sign=4'hF.
- o_digits values other than 0-9 occur only as 4'hF (blank). Any other value is a bug.
- cnt width is clog2(DW+1).

Test Plan:
- Reset, then hold i_rst=1 for 2 cycles -> o_rdy=0, o_busy=0, o_digits=0, o_sign=4'hF. Pulse i_start with i_rst=1 -> no effect.
- i_data=16'd1234, one-cycle i_start at edge k -> o_busy=1 on edges k..k+15. At edge k+16: o_rdy=1, o_digits=0_1_2_3_4, o_sign=4'hF.
- i_data=16'hFFFF (-1) -> o_digits=0_0_0_0_1, o_sign=10. i_data=16'h8000 (-32768) -> 3_2_7_6_8, o_sign=10. i_data=16'h7FFF -> 3_2_7_6_7, o_sign=4'hF.
- BLANK_LZ=1: i_data=0 -> F_F_F_F_0, o_sign=F. i_data=-5 -> F_F_F_F_5, o_sign=10. i_data=10000 -> 1_0_0_0_0.
- Convert 42, then pulse i_start with 99 at edge k+5 (during SHIFT) -> ignored; result=0_0_0_4_2. A new i_start in DONE -> o_rdy drops next edge, old digits held, result 0_0_0_9_9 after 16 cycles.
- Assert i_rst at cnt=8 mid-conversion -> next edge IDLE, o_rdy=0, o_digits=0. A following conversion of 7 gives 0_0_0_0_7 with the correct 16-cycle latency.
